cc3000fpga_mss: RTL and testbench
=================================

# cc3000fpga_mss

Behavioural model of the cc3000fpga microcontroller subsystem. It is the processor side of the design: a UART command port (UART_0) drives an APB master into the FPGA fabric, and it also provides general-purpose outputs, a fabric reset and a UART_1 echo. It sits at the top of the fabric hierarchy, and fabric peripherals hang off its APB port.

## Interface
- CLK_DIV, 87: SYSCLK cycles per UART bit (10 MHz / 115200).
- APB_TIMEOUT, 255: maximum ACCESS cycles waiting for MSSPREADY.
- SYSCLK  in  1  single system clock; all logic is on its rising edge.
- MSS_RESET_N  in  1  reset; asynchronous, active-low.
- FAB_CLK  out  1  fabric clock; combinational copy of SYSCLK.
- M2F_RESET_N  out  1  fabric reset, active-low.
- MSSPSEL, MSSPENABLE, MSSPWRITE  out  1 each  APB master control.
- MSSPADDR  out  20  APB address.
- MSSPWDATA  out  32  APB write data.
- MSSPRDATA  in  32  APB read data.
- MSSPREADY, MSSPSLVERR  in  1 each  APB completion and error.
- UART_0_RXD / UART_0_TXD  in/out  1  command port, 8N1.
- UART_1_RXD / UART_1_TXD  in/out  1  echo port.
- M2F_GPO_0, M2F_GPO_1, M2F_GPO_3, IO_4_PADOUT  out  1 each  general-purpose outputs.
- F2M_GPI_29, F2M_GPI_30, F2M_GPI_31, GPIO_2_IN, IO_4_D, FABINT  in  1 each  general-purpose and interrupt inputs.

## Operation
- Reset state:
  - MSSPSEL, MSSPENABLE, MSSPWRITE, MSSPADDR and MSSPWDATA are 0.
  - All GPOs and IO_4_PADOUT are 0.
  - UART TXDs are 1 (idle).
  - M2F_RESET_N is 0.
  - Command FSM is in IDLE.
- M2F_RESET_N:
  - Asserts (goes 0) asynchronously when MSS_RESET_N is low.
  - Deasserts through a 2-flop synchronizer.
- UART_1_TXD is UART_1_RXD delayed through a 2-flop synchronizer. Its reset value is 1.
- UART receiver:
  - Double-synchronizes RXD.
  - A falling edge starts a frame. The start bit is re-checked at mid-bit (CLK_DIV/2), and if it is not low the frame is abandoned.
  - Data bits are sampled LSB first, every CLK_DIV cycles.
  - If the stop bit is 0, the byte is dropped.
- Command FSM states: IDLE, ARGS, APB_SETUP, APB_ACCESS, RESP.
  - 0x57 'W' + 3 address bytes + 4 data bytes (MSB first): APB write.
  - 0x52 'R' + 3 address bytes: APB read.
  - 0x47 'G' + 1 byte: sets GPOs. Bit 0 drives M2F_GPO_0, bit 1 drives M2F_GPO_1, bit 3 drives M2F_GPO_3, bit 4 drives IO_4_PADOUT.
  - 0x49 'I': replies with ACK, then the status byte {2'b0, FABINT, GPIO_2_IN, F2M_GPI_31, F2M_GPI_30, F2M_GPI_29, IO_4_D} (MSB first).
  - Any other opcode: reply NAK (0x15) and return to IDLE.
- Addressing: MSSPADDR takes the low 20 bits of the 24-bit received address; bits 23:20 are ignored.
- Write responses:
  - 'W' replies ACK (0x06) on success.
  - 'W' replies NAK if MSSPSLVERR=1 at completion or on timeout.
- Read responses:
  - 'R' replies ACK followed by 4 MSSPRDATA bytes, MSB first.
  - On error or timeout, 'R' replies NAK only; no data bytes follow.
- 'G' replies ACK.
- Bytes that arrive while the FSM is in APB_* or RESP are discarded.

## Timing
- APB SETUP phase: one cycle with MSSPSEL=1, MSSPENABLE=0. MSSPADDR, MSSPWRITE and MSSPWDATA are valid in this cycle.
- APB ACCESS phase: MSSPENABLE=1 and held until the cycle in which MSSPREADY=1 is sampled.
- On completion:
  - Both MSSPSEL and MSSPENABLE go to 0 on the next edge.
  - MSSPRDATA and MSSPSLVERR are captured on the completion edge.
- Timeout: APB_TIMEOUT ACCESS cycles without MSSPREADY aborts the transfer (MSSPSEL and MSSPENABLE drop to 0) and produces a NAK.
- The first response start bit begins within 2 cycles of APB completion. Response bytes are sent back-to-back, each with one stop bit.
- MSSPADDR and MSSPWDATA hold their last values between transfers.
- Reset mid-operation: all state returns to reset values immediately; any partially transmitted TXD frame is cut to idle 1.

## Configuration
- MSS_APB_TIMEOUT_EN defined: the timeout counter and timeout NAK are implemented.
- MSS_APB_TIMEOUT_EN undefined: ACCESS waits indefinitely for MSSPREADY, and the APB_TIMEOUT parameter is unused.

## Structure
- Package cc3000fpga_mss_pkg holds:
  - opcode constants (W/R/G/I);
  - ACK/NAK constants;
  - the FSM state enum;
  - GPO bit-index constants.
- Sub-module cc3000fpga_mss_uart contains the RX and TX engines, parameterized by CLK_DIV, and is instantiated for UART_0.
- The top level contains the command FSM, the APB master, the GPOs, the reset synchronizer and the UART_1 echo.

## Test plan
- Reset: hold MSS_RESET_N=0 for 10 cycles, then release. Expect:
  - all outputs at their reset values;
  - M2F_RESET_N rises exactly 2 SYSCLK edges after release.
- Write: send 57 01 23 45 DE AD BE EF with MSSPREADY=1 and MSSPSLVERR=0. Expect:
  - exactly one SETUP and one ACCESS cycle;
  - MSSPADDR=0x12345, MSSPWDATA=0xDEADBEEF, MSSPWRITE=1;
  - reply 06.
- Read with wait states: send 52 00 00 10 with MSSPREADY low for 3 ACCESS cycles and MSSPRDATA=0xCAFEF00D. Expect reply 06 CA FE F0 0D.
- Error and timeout:
  - Read with MSSPSLVERR=1 at completion: expect reply 15 only.
  - With MSSPREADY tied 0 and the macro defined: expect the abort after 255 ACCESS cycles, then reply 15.
- GPIO: send 47 1B, then 49 with IO_4_D=1 and FABINT=1. Expect:
  - M2F_GPO_0=1, M2F_GPO_1=1, M2F_GPO_3=1, IO_4_PADOUT=1;
  - reply 06 21.
- Framing and echo:
  - Glitch RXD low for less than half a bit: no byte is received.
  - Unknown opcode 0x00: reply 15.
  - UART_1_TXD follows UART_1_RXD with 2-cycle latency.

Source files
------------

// File: rtl/cc3000fpga_mss_pkg.sv
// Shared constants and state types for the cc3000fpga microcontroller subsystem model.
// Optional APB timeout is enabled by defining MSS_APB_TIMEOUT_EN.
package cc3000fpga_mss_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_GPO   = 8'h47;
  localparam logic [7:0] OP_INFO  = 8'h49;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam int GPO_0_BIT = 0;
  localparam int GPO_1_BIT = 1;
  localparam int GPO_3_BIT = 3;
  localparam int IO_4_BIT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_APB_SETUP,
    ST_APB_ACCESS,
    ST_RESP
  } cmd_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_e;

endpackage

// File: rtl/cc3000fpga_mss_uart.sv
// 8N1 UART receive and transmit engines; CLK_DIV clock cycles per bit.
// rx_valid pulses one cycle with rx_data; a tx byte transfers on any cycle where tx_valid && tx_ready.
module cc3000fpga_mss_uart
  import cc3000fpga_mss_pkg::*;
#(
  parameter int CLK_DIV = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [1:0] rx_state_dbg,
  output logic       tx_state_dbg
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [8:0]      tx_shift_q, tx_shift_d;
  logic            txd_q, txd_d;
  logic            tx_done;

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign txd          = txd_q;
  assign rx_state_dbg = rx_state_q;
  assign tx_state_dbg = tx_state_q;

  always_comb begin
    rx_s1_d    = rxd;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Ready again in the last stop-bit cycle so response bytes run back-to-back.
  assign tx_done  = (tx_state_q == TX_SHIFT) && (tx_cnt_q == DIV_LAST) && (tx_bit_q == 4'd9);
  assign tx_ready = (tx_state_q == TX_IDLE) || tx_done;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    if (tx_state_q == TX_SHIFT) begin
      if (tx_cnt_q == DIV_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_state_d = TX_IDLE;
          txd_d      = 1'b1;
        end else begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
    if (tx_valid && tx_ready) begin
      tx_state_d = TX_SHIFT;
      tx_cnt_d   = '0;
      tx_bit_d   = 4'd0;
      tx_shift_d = {1'b1, tx_data};
      txd_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= 9'h1ff;
      txd_q      <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: rtl/cc3000fpga_mss.sv
// Microcontroller subsystem model: UART_0 command port driving an APB master, GPOs,
// fabric reset synchronizer and UART_1 echo. Define MSS_APB_TIMEOUT_EN for the APB timeout.
module cc3000fpga_mss
  import cc3000fpga_mss_pkg::*;
#(
  parameter int CLK_DIV     = 87,
  parameter int APB_TIMEOUT = 255
) (
  input  logic        SYSCLK,
  input  logic        MSS_RESET_N,
  output logic        FAB_CLK,
  output logic        M2F_RESET_N,
  output logic        MSSPSEL,
  output logic        MSSPENABLE,
  output logic        MSSPWRITE,
  output logic [19:0] MSSPADDR,
  output logic [31:0] MSSPWDATA,
  input  logic [31:0] MSSPRDATA,
  input  logic        MSSPREADY,
  input  logic        MSSPSLVERR,
  input  logic        UART_0_RXD,
  output logic        UART_0_TXD,
  input  logic        UART_1_RXD,
  output logic        UART_1_TXD,
  output logic        M2F_GPO_0,
  output logic        M2F_GPO_1,
  output logic        M2F_GPO_3,
  output logic        IO_4_PADOUT,
  input  logic        F2M_GPI_29,
  input  logic        F2M_GPI_30,
  input  logic        F2M_GPI_31,
  input  logic        GPIO_2_IN,
  input  logic        IO_4_D,
  input  logic        FABINT
);

  cmd_state_e  state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [55:0] args_q, args_d;
  logic [2:0]  args_left_q, args_left_d;
  logic [19:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic [39:0] resp_q, resp_d;
  logic [2:0]  resp_left_q, resp_left_d;
  logic        gpo_0_q, gpo_0_d, gpo_1_q, gpo_1_d, gpo_3_q, gpo_3_d, io_4_q, io_4_d;
  logic [1:0]  rst_sync_q, rst_sync_d;
  logic [1:0]  echo_q, echo_d;
`ifdef MSS_APB_TIMEOUT_EN
  localparam int TW = $clog2(APB_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(APB_TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  logic [7:0] rx_data, tx_data, status_byte;
  logic       rx_valid, tx_valid, tx_ready;
  logic [1:0] uart_rx_state;
  logic       uart_tx_state;
  logic       unused_bits;

  cc3000fpga_mss_uart #(.CLK_DIV(CLK_DIV)) u_uart_0 (
    .clk          (SYSCLK),
    .rst_n        (MSS_RESET_N),
    .rxd          (UART_0_RXD),
    .txd          (UART_0_TXD),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_state_dbg (uart_rx_state),
    .tx_state_dbg (uart_tx_state)
  );

  assign FAB_CLK     = SYSCLK;
  assign M2F_RESET_N = rst_sync_q[1];
  assign UART_1_TXD  = echo_q[1];
  assign MSSPSEL     = (state_q == ST_APB_SETUP) || (state_q == ST_APB_ACCESS);
  assign MSSPENABLE  = (state_q == ST_APB_ACCESS);
  assign MSSPWRITE   = pwrite_q;
  assign MSSPADDR    = paddr_q;
  assign MSSPWDATA   = pwdata_q;
  assign M2F_GPO_0   = gpo_0_q;
  assign M2F_GPO_1   = gpo_1_q;
  assign M2F_GPO_3   = gpo_3_q;
  assign IO_4_PADOUT = io_4_q;
  assign status_byte = {2'b00, FABINT, GPIO_2_IN, F2M_GPI_31, F2M_GPI_30, F2M_GPI_29, IO_4_D};

`ifdef MSS_APB_TIMEOUT_EN
  assign unused_bits = ^{args_q[55:48], uart_rx_state, uart_tx_state};
`else
  assign unused_bits = (^{args_q[55:48], uart_rx_state, uart_tx_state}) ^ (APB_TIMEOUT == 0);
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    args_d      = args_q;
    args_left_d = args_left_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    gpo_0_d     = gpo_0_q;
    gpo_1_d     = gpo_1_q;
    gpo_3_d     = gpo_3_q;
    io_4_d      = io_4_q;
    rst_sync_d  = {rst_sync_q[0], 1'b1};
    echo_d      = {echo_q[0], UART_1_RXD};
    tx_valid    = 1'b0;
    tx_data     = resp_q[39:32];
`ifdef MSS_APB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          op_d = rx_data;
          case (rx_data)
            OP_WRITE: begin args_left_d = 3'd7; state_d = ST_ARGS; end
            OP_READ:  begin args_left_d = 3'd3; state_d = ST_ARGS; end
            OP_GPO:   begin args_left_d = 3'd1; state_d = ST_ARGS; end
            OP_INFO: begin
              resp_d      = {ACK, status_byte, 24'h0};
              resp_left_d = 3'd2;
              state_d     = ST_RESP;
            end
            default: begin
              resp_d      = {NAK, 32'h0};
              resp_left_d = 3'd1;
              state_d     = ST_RESP;
            end
          endcase
        end
      end
      ST_ARGS: begin
        // Arguments arrive MSB first and are shifted in from the bottom.
        if (rx_valid) begin
          args_d      = {args_q[47:0], rx_data};
          args_left_d = args_left_q - 3'd1;
          if (args_left_q == 3'd1) begin
            case (op_q)
              OP_WRITE: begin
                paddr_d  = args_d[51:32];
                pwdata_d = args_d[31:0];
                pwrite_d = 1'b1;
                state_d  = ST_APB_SETUP;
              end
              OP_READ: begin
                paddr_d  = args_d[19:0];
                pwrite_d = 1'b0;
                state_d  = ST_APB_SETUP;
              end
              default: begin
                gpo_0_d     = rx_data[GPO_0_BIT];
                gpo_1_d     = rx_data[GPO_1_BIT];
                gpo_3_d     = rx_data[GPO_3_BIT];
                io_4_d      = rx_data[IO_4_BIT];
                resp_d      = {ACK, 32'h0};
                resp_left_d = 3'd1;
                state_d     = ST_RESP;
              end
            endcase
          end
        end
      end
      ST_APB_SETUP: begin
        state_d = ST_APB_ACCESS;
`ifdef MSS_APB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_APB_ACCESS: begin
        if (MSSPREADY) begin
          state_d = ST_RESP;
          if (MSSPSLVERR) begin
            resp_d      = {NAK, 32'h0};
            resp_left_d = 3'd1;
          end else if (pwrite_q) begin
            resp_d      = {ACK, 32'h0};
            resp_left_d = 3'd1;
          end else begin
            resp_d      = {ACK, MSSPRDATA};
            resp_left_d = 3'd5;
          end
        end
`ifdef MSS_APB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d     = ST_RESP;
          resp_d      = {NAK, 32'h0};
          resp_left_d = 3'd1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          resp_d      = {resp_q[31:0], 8'h00};
          resp_left_d = resp_left_q - 3'd1;
          if (resp_left_q == 3'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state_q     <= ST_IDLE;
      op_q        <= 8'h00;
      args_q      <= 56'h0;
      args_left_q <= 3'd0;
      paddr_q     <= 20'h0;
      pwdata_q    <= 32'h0;
      pwrite_q    <= 1'b0;
      resp_q      <= 40'h0;
      resp_left_q <= 3'd0;
      gpo_0_q     <= 1'b0;
      gpo_1_q     <= 1'b0;
      gpo_3_q     <= 1'b0;
      io_4_q      <= 1'b0;
      rst_sync_q  <= 2'b00;
      echo_q      <= 2'b11;
`ifdef MSS_APB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      args_q      <= args_d;
      args_left_q <= args_left_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      gpo_0_q     <= gpo_0_d;
      gpo_1_q     <= gpo_1_d;
      gpo_3_q     <= gpo_3_d;
      io_4_q      <= io_4_d;
      rst_sync_q  <= rst_sync_d;
      echo_q      <= echo_d;
`ifdef MSS_APB_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_cc3000fpga_mss.sv
// Scoreboard bench for cc3000fpga_mss: UART commands in, decoded reply bytes and APB
// transfers checked against expected queues filled by the stimulus.
module tb_cc3000fpga_mss;

  localparam int CLK_DIV = 87;

  logic        SYSCLK = 1'b0;
  logic        MSS_RESET_N = 1'b0;
  logic        FAB_CLK, M2F_RESET_N, MSSPSEL, MSSPENABLE, MSSPWRITE;
  logic [19:0] MSSPADDR;
  logic [31:0] MSSPWDATA;
  logic [31:0] MSSPRDATA = 32'h0;
  logic        MSSPREADY = 1'b0, MSSPSLVERR = 1'b0;
  logic        UART_0_RXD = 1'b1, UART_1_RXD = 1'b1;
  logic        UART_0_TXD, UART_1_TXD;
  logic        M2F_GPO_0, M2F_GPO_1, M2F_GPO_3, IO_4_PADOUT;
  logic        F2M_GPI_29 = 1'b0, F2M_GPI_30 = 1'b0, F2M_GPI_31 = 1'b0;
  logic        GPIO_2_IN = 1'b0, IO_4_D = 1'b0, FABINT = 1'b0;

  cc3000fpga_mss #(.CLK_DIV(CLK_DIV), .APB_TIMEOUT(255)) dut (
    .SYSCLK(SYSCLK), .MSS_RESET_N(MSS_RESET_N), .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N),
    .MSSPSEL(MSSPSEL), .MSSPENABLE(MSSPENABLE), .MSSPWRITE(MSSPWRITE), .MSSPADDR(MSSPADDR),
    .MSSPWDATA(MSSPWDATA), .MSSPRDATA(MSSPRDATA), .MSSPREADY(MSSPREADY), .MSSPSLVERR(MSSPSLVERR),
    .UART_0_RXD(UART_0_RXD), .UART_0_TXD(UART_0_TXD), .UART_1_RXD(UART_1_RXD), .UART_1_TXD(UART_1_TXD),
    .M2F_GPO_0(M2F_GPO_0), .M2F_GPO_1(M2F_GPO_1), .M2F_GPO_3(M2F_GPO_3), .IO_4_PADOUT(IO_4_PADOUT),
    .F2M_GPI_29(F2M_GPI_29), .F2M_GPI_30(F2M_GPI_30), .F2M_GPI_31(F2M_GPI_31),
    .GPIO_2_IN(GPIO_2_IN), .IO_4_D(IO_4_D), .FABINT(FABINT)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 SYSCLK = ~SYSCLK;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [19:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [8:0]  acc;
  } apb_exp_t;

  logic [7:0] exp_q[$];
  apb_exp_t   apb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         apb_wait = 0;
  int         acc_cnt = 0;
  int         cur_acc = 0;
  logic       in_xfer = 1'b0;
  apb_exp_t   apb_e;
  logic [7:0] mon_b;
  logic       mon_stop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    UART_0_RXD = 1'b0;
    repeat (CLK_DIV) @(negedge SYSCLK);
    for (int i = 0; i < 8; i++) begin
      UART_0_RXD = b[i];
      repeat (CLK_DIV) @(negedge SYSCLK);
    end
    UART_0_RXD = 1'b1;
    repeat (CLK_DIV) @(negedge SYSCLK);
  endtask

  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 9000) begin
      @(negedge SYSCLK);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      fail_now({name, "_reply_timeout"}, 64'(exp_q.size()));
      exp_q.delete();
    end
    repeat (2 * CLK_DIV) @(negedge SYSCLK);
  endtask

  // ---------------- monitors ----------------
  // UART_0 reply decoder: compares each received frame against the expected queue.
  initial begin
    forever begin
      @(negedge SYSCLK);
      if (MSS_RESET_N && UART_0_TXD == 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge SYSCLK);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge SYSCLK);
          mon_b[i] = UART_0_TXD;
        end
        repeat (CLK_DIV) @(negedge SYSCLK);
        mon_stop = UART_0_TXD;
        if (exp_q.size() == 0) fail_now("uart_unexpected_byte", {55'h0, mon_stop, mon_b});
        else chk("uart_reply", {55'h0, mon_stop, mon_b}, {55'h0, 1'b1, exp_q.pop_front()});
      end
    end
  end

  // APB slave model and transfer checker.
  initial begin
    forever begin
      @(negedge SYSCLK);
      if (!MSS_RESET_N) begin
        MSSPREADY = 1'b0;
        in_xfer = 1'b0;
      end else begin
        if (MSSPSEL && !MSSPENABLE) begin
          if (apb_q.size() == 0) begin
            fail_now("apb_unexpected_setup", {44'h0, MSSPADDR});
          end else begin
            apb_e = apb_q.pop_front();
            chk("apb_addr", {44'h0, MSSPADDR}, {44'h0, apb_e.addr});
            chk("apb_write", {63'h0, MSSPWRITE}, {63'h0, apb_e.write});
            if (apb_e.write) chk("apb_wdata", {32'h0, MSSPWDATA}, {32'h0, apb_e.wdata});
            cur_acc = int'(apb_e.acc);
          end
          acc_cnt = 0;
          in_xfer = 1'b1;
        end
        if (MSSPSEL && MSSPENABLE) begin
          MSSPREADY = (acc_cnt == apb_wait);
          acc_cnt++;
        end else begin
          MSSPREADY = 1'b0;
          if (in_xfer && !MSSPSEL) begin
            chk("apb_access_cycles", 64'(acc_cnt), 64'(cur_acc));
            in_xfer = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (10) @(negedge SYSCLK);
    chk("rst_apb_ctrl", {61'h0, MSSPSEL, MSSPENABLE, MSSPWRITE}, 64'h0);
    chk("rst_apb_addr_wdata", {12'h0, MSSPADDR, MSSPWDATA}, 64'h0);
    chk("rst_gpo", {60'h0, M2F_GPO_0, M2F_GPO_1, M2F_GPO_3, IO_4_PADOUT}, 64'h0);
    chk("rst_txd", {62'h0, UART_0_TXD, UART_1_TXD}, 64'h3);
    chk("rst_m2f_low", {63'h0, M2F_RESET_N}, 64'h0);

    MSS_RESET_N = 1'b1;
    @(posedge SYSCLK); #1;
    chk("m2f_rst_edge1", {63'h0, M2F_RESET_N}, 64'h0);
    @(posedge SYSCLK); #1;
    chk("m2f_rst_edge2", {63'h0, M2F_RESET_N}, 64'h1);
    repeat (20) @(negedge SYSCLK);

    // Write, zero wait states
    apb_wait = 0;
    apb_q.push_back('{addr: 20'h12345, write: 1'b1, wdata: 32'hDEADBEEF, acc: 9'd1});
    exp_q.push_back(8'h06);
    send_bytes(64'h57012345DEADBEEF, 8);
    wait_drain("write");
    chk("hold_addr", {44'h0, MSSPADDR}, 64'h12345);
    chk("hold_wdata", {32'h0, MSSPWDATA}, 64'hDEADBEEF);
    chk("idle_psel", {62'h0, MSSPSEL, MSSPENABLE}, 64'h0);

    // Read with three wait states
    apb_wait = 3;
    MSSPRDATA = 32'hCAFEF00D;
    apb_q.push_back('{addr: 20'h00010, write: 1'b0, wdata: 32'h0, acc: 9'd4});
    exp_q.push_back(8'h06); exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    send_bytes(64'h52000010, 4);
    wait_drain("read_wait");

    // Read with slave error
    apb_wait = 0;
    MSSPSLVERR = 1'b1;
    apb_q.push_back('{addr: 20'h00020, write: 1'b0, wdata: 32'h0, acc: 9'd1});
    exp_q.push_back(8'h15);
    send_bytes(64'h52000020, 4);
    wait_drain("read_err");
    MSSPSLVERR = 1'b0;

    // Write with address bits 23:20 set (ignored)
    apb_q.push_back('{addr: 20'h00004, write: 1'b1, wdata: 32'h00000001, acc: 9'd1});
    exp_q.push_back(8'h06);
    send_bytes(64'h57F0000400000001, 8);
    wait_drain("write_hi_addr");

`ifdef MSS_APB_TIMEOUT_EN
    apb_wait = 100000;
    apb_q.push_back('{addr: 20'h00030, write: 1'b0, wdata: 32'h0, acc: 9'd255});
    exp_q.push_back(8'h15);
    send_bytes(64'h52000030, 4);
    wait_drain("timeout");
    apb_wait = 0;
`endif

    // GPO set and status read
    exp_q.push_back(8'h06);
    send_bytes(64'h471B, 2);
    wait_drain("gpo_set");
    chk("gpo_1b", {60'h0, M2F_GPO_0, M2F_GPO_1, M2F_GPO_3, IO_4_PADOUT}, 64'hF);
    IO_4_D = 1'b1;
    FABINT = 1'b1;
    exp_q.push_back(8'h06); exp_q.push_back(8'h21);
    send_bytes(64'h49, 1);
    wait_drain("info");
    exp_q.push_back(8'h06);
    send_bytes(64'h4704, 2);
    wait_drain("gpo_clear");
    chk("gpo_04", {60'h0, M2F_GPO_0, M2F_GPO_1, M2F_GPO_3, IO_4_PADOUT}, 64'h0);

    // Short glitch on RXD must not produce a frame
    UART_0_RXD = 1'b0;
    repeat (20) @(negedge SYSCLK);
    UART_0_RXD = 1'b1;
    repeat (12 * CLK_DIV) @(negedge SYSCLK);
    chk("glitch_no_reply_pending", 64'(exp_q.size()), 64'h0);

    // Unknown opcode
    exp_q.push_back(8'h15);
    send_bytes(64'h00, 1);
    wait_drain("unknown_op");

    // UART_1 echo latency
    UART_1_RXD = 1'b0;
    @(posedge SYSCLK); #1;
    chk("echo_fall_edge1", {63'h0, UART_1_TXD}, 64'h1);
    @(posedge SYSCLK); #1;
    chk("echo_fall_edge2", {63'h0, UART_1_TXD}, 64'h0);
    @(negedge SYSCLK);
    UART_1_RXD = 1'b1;
    @(posedge SYSCLK); #1;
    chk("echo_rise_edge1", {63'h0, UART_1_TXD}, 64'h0);
    @(posedge SYSCLK); #1;
    chk("echo_rise_edge2", {63'h0, UART_1_TXD}, 64'h1);

    repeat (50) @(negedge SYSCLK);
    chk("apb_pending", 64'(apb_q.size()), 64'h0);
    chk("reply_pending", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
